// File: rtl/dbg_cmd_pkg.sv
// Shared types and helpers for the CPU debug command bridge.
// The optional counters are enabled with `DBG_CMD_STATS_EN (see sys_cpu_dbg_cmd_bridge).
package dbg_cmd_pkg;

  localparam int CNT_W      = 16;
  localparam int DEF_IR_W   = 2;
  localparam int DEF_DATA_W = 38;

  typedef struct packed {
    logic [DEF_IR_W-1:0]   ir;
    logic [DEF_DATA_W-1:0] data;
  } dbg_cmd_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Synchronous command FIFO with flush; flush wins over pop, a push in the same
// cycle as a flush survives as the only entry.
module dbg_cmd_fifo
  import dbg_cmd_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = dbg_cmd_t
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  T     i_data,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int             PTR_W   = clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  T               r_mem [DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/sys_cpu_dbg_cmd_bridge.sv
// System-clock side of the CPU JTAG debug path: strobe sync, command FIFO, action decode.
// Define DBG_CMD_STATS_EN to build the saturating accepted/dropped command counters.
module sys_cpu_dbg_cmd_bridge
  import dbg_cmd_pkg::*;
#(
  parameter int IR_W         = DEF_IR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ACT_BIT      = 34,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int FLUSH_ON_UIR = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [IR_W-1:0]       i_ir_in,
  input  logic [DATA_W-1:0]     i_sr,
  input  logic                  i_vs_udr,
  input  logic                  i_vs_uir,
  input  logic                  i_cmd_ready,
  output logic                  o_cmd_valid,
  output logic [IR_W-1:0]       o_cmd_ir,
  output logic [DATA_W-1:0]     o_jdo,
  output logic [(2**IR_W)-1:0]  o_take_action,
  output logic [(2**IR_W)-1:0]  o_take_no_action,
  output logic                  o_ir_upd,
  output logic                  o_overflow,
  output logic [CNT_W-1:0]      o_cmd_count,
  output logic [CNT_W-1:0]      o_drop_count
);

  localparam int NUM_IR = 2**IR_W;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_d;
  logic                   r_udr_d2;
  logic                   r_uir_d;
  logic                   r_uir_d2;
  logic                   r_udr_stb;
  logic                   r_uir_stb;
  logic [DATA_W-1:0]      r_jdo;
  logic [NUM_IR-1:0]      r_take_action;
  logic [NUM_IR-1:0]      r_take_no_action;
  logic                   r_overflow;

  cmd_t                   w_push_cmd;
  cmd_t                   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic                   w_drop;
  logic [NUM_IR-1:0]      w_ir_onehot;

  // Strobes are registered after the edge flop so sr has settled by the push.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_d    <= 1'b0;
      r_udr_d2   <= 1'b0;
      r_uir_d    <= 1'b0;
      r_uir_d2   <= 1'b0;
      r_udr_stb  <= 1'b0;
      r_uir_stb  <= 1'b0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], i_vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], i_vs_uir};
      r_udr_d    <= r_udr_sync[SYNC_STAGES-1];
      r_udr_d2   <= r_udr_d;
      r_uir_d    <= r_uir_sync[SYNC_STAGES-1];
      r_uir_d2   <= r_uir_d;
      r_udr_stb  <= r_udr_d & ~r_udr_d2;
      r_uir_stb  <= r_uir_d & ~r_uir_d2;
    end
  end

  assign w_push_cmd = '{ir: i_ir_in, data: i_sr};
  assign w_flush    = r_uir_stb && (FLUSH_ON_UIR != 0);
  assign w_pop      = !w_empty && i_cmd_ready;
  assign w_push     = r_udr_stb && (!w_full || w_pop || w_flush);
  assign w_drop     = r_udr_stb && w_full && !w_pop && !w_flush;

  dbg_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_data    (w_push_cmd),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    w_ir_onehot              = '0;
    w_ir_onehot[w_head.ir]   = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_overflow       <= 1'b0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo <= w_head.data;
        if (w_head.data[ACT_BIT]) begin
          r_take_action <= w_ir_onehot;
        end else begin
          r_take_no_action <= w_ir_onehot;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef DBG_CMD_STATS_EN
  logic [CNT_W-1:0] r_cmd_count;
  logic [CNT_W-1:0] r_drop_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cmd_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push && (r_cmd_count != '1)) begin
        r_cmd_count <= r_cmd_count + CNT_W'(1);
      end
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end
  end

  assign o_cmd_count  = r_cmd_count;
  assign o_drop_count = r_drop_count;
`else
  assign o_cmd_count  = '0;
  assign o_drop_count = '0;
`endif

  // Head IR is forced to zero when empty so stale memory never leaks out.
  assign o_cmd_valid      = !w_empty;
  assign o_cmd_ir         = w_empty ? '0 : w_head.ir;
  assign o_jdo            = r_jdo;
  assign o_take_action    = r_take_action;
  assign o_take_no_action = r_take_no_action;
  assign o_ir_upd         = r_uir_stb;
  assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_sys_cpu_dbg_cmd_bridge.sv
// Directed self-checking bench for sys_cpu_dbg_cmd_bridge (SYNC_STAGES=3, DEPTH=4).
// Counter checks follow DBG_CMD_STATS_EN.
module tb_sys_cpu_dbg_cmd_bridge;

  localparam int IR_W   = 2;
  localparam int DATA_W = 38;
  localparam int NUM_IR = 4;

  localparam logic [DATA_W-1:0] D_A = 38'h05_1234_5678;
  localparam logic [DATA_W-1:0] D_B = 38'h2B_8765_4321;
  localparam logic [DATA_W-1:0] F0  = 38'h04_0000_0001;
  localparam logic [DATA_W-1:0] F1  = 38'h00_0000_0002;
  localparam logic [DATA_W-1:0] F2  = 38'h3C_0000_0003;
  localparam logic [DATA_W-1:0] F3  = 38'h01_0000_0004;
  localparam logic [DATA_W-1:0] F4  = 38'h1F_FFFF_FFFF;
  localparam logic [DATA_W-1:0] F5  = 38'h22_2222_2222;

  logic                clk = 1'b0;
  logic                resetN = 1'b0;
  logic [IR_W-1:0]     irIn = '0;
  logic [DATA_W-1:0]   sr = '0;
  logic                vsUdr = 1'b0;
  logic                vsUir = 1'b0;
  logic                cmdReady = 1'b0;
  logic                cmdValid;
  logic [IR_W-1:0]     cmdIr;
  logic [DATA_W-1:0]   jdo;
  logic [NUM_IR-1:0]   takeAction;
  logic [NUM_IR-1:0]   takeNoAction;
  logic                irUpd;
  logic                overflow;
  logic [15:0]         cmdCount;
  logic [15:0]         dropCount;

  int testCount = 0;
  int failCount = 0;

  sys_cpu_dbg_cmd_bridge #(
    .IR_W        (IR_W),
    .DATA_W      (DATA_W),
    .ACT_BIT     (34),
    .DEPTH       (4),
    .SYNC_STAGES (3),
    .FLUSH_ON_UIR(1)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (resetN),
    .i_ir_in          (irIn),
    .i_sr             (sr),
    .i_vs_udr         (vsUdr),
    .i_vs_uir         (vsUir),
    .i_cmd_ready      (cmdReady),
    .o_cmd_valid      (cmdValid),
    .o_cmd_ir         (cmdIr),
    .o_jdo            (jdo),
    .o_take_action    (takeAction),
    .o_take_no_action (takeNoAction),
    .o_ir_upd         (irUpd),
    .o_overflow       (overflow),
    .o_cmd_count      (cmdCount),
    .o_drop_count     (dropCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One update-DR pulse; the push lands on the 6th edge, the rest is settling time.
  task automatic applyStimulus(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] data);
    irIn  = ir;
    sr    = data;
    vsUdr = 1'b1;
    tick();
    tick();
    vsUdr = 1'b0;
    repeat (6) tick();
  endtask

  task automatic popAndCheck(input string tag, input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] data);
    logic [63:0] mask;
    mask = 64'd1 << ir;
    checkOutput({tag, "_ir"}, 64'(cmdIr), 64'(ir));
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
    checkOutput({tag, "_jdo"}, 64'(jdo), 64'(data));
    checkOutput({tag, "_act"}, 64'(takeAction), data[34] ? mask : 64'd0);
    checkOutput({tag, "_noact"}, 64'(takeNoAction), data[34] ? 64'd0 : mask);
  endtask

  task automatic checkCounts(input string tag, input int expCmd, input int expDrop);
`ifdef DBG_CMD_STATS_EN
    checkOutput({tag, "_cmdcnt"}, 64'(cmdCount), 64'(expCmd));
    checkOutput({tag, "_dropcnt"}, 64'(dropCount), 64'(expDrop));
`else
    checkOutput({tag, "_cmdcnt"}, 64'(cmdCount), 64'(expCmd * 0));
    checkOutput({tag, "_dropcnt"}, 64'(dropCount), 64'(expDrop * 0));
`endif
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    checkOutput("rst_valid", 64'(cmdValid), 64'd0);
    checkOutput("rst_ir", 64'(cmdIr), 64'd0);
    checkOutput("rst_jdo", 64'(jdo), 64'd0);
    checkOutput("rst_act", 64'(takeAction), 64'd0);
    checkOutput("rst_noact", 64'(takeNoAction), 64'd0);
    checkOutput("rst_irupd", 64'(irUpd), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkCounts("rst", 0, 0);
    resetN = 1'b1;
    tick();

    // Latency: first sample of vs_udr is edge 0, cmd_valid rises after edge 5
    irIn  = 2'd1;
    sr    = D_A;
    vsUdr = 1'b1;
    tick();
    tick();
    vsUdr = 1'b0;
    repeat (3) tick();
    checkOutput("lat_early", 64'(cmdValid), 64'd0);
    tick();
    checkOutput("lat_valid", 64'(cmdValid), 64'd1);
    tick();
    tick();

    // Single command with action bit set
    popAndCheck("single", 2'd1, D_A);
    tick();
    checkOutput("single_pulse_end", 64'(takeAction), 64'd0);
    checkOutput("single_empty", 64'(cmdValid), 64'd0);

    // Action bit clear routes to take_no_action
    applyStimulus(2'd3, D_B);
    checkOutput("noact_valid", 64'(cmdValid), 64'd1);
    popAndCheck("noact", 2'd3, D_B);

    // Fill to DEPTH with no consumer
    applyStimulus(2'd0, F0);
    applyStimulus(2'd1, F1);
    applyStimulus(2'd2, F2);
    applyStimulus(2'd3, F3);
    checkOutput("fill_ovf", 64'(overflow), 64'd0);
    checkOutput("fill_head", 64'(cmdIr), 64'd0);

    // Full with push and pop on the same edge
    irIn  = 2'd1;
    sr    = F4;
    vsUdr = 1'b1;
    tick();
    tick();
    vsUdr = 1'b0;
    repeat (3) tick();
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
    checkOutput("fullpop_jdo", 64'(jdo), 64'(F0));
    checkOutput("fullpop_act", 64'(takeAction), 64'h1);
    checkOutput("fullpop_ovf", 64'(overflow), 64'd0);
    tick();
    tick();

    // Full with push only drops the entry
    applyStimulus(2'd2, F5);
    checkOutput("drop_ovf", 64'(overflow), 64'd1);
    checkCounts("drop", 7, 1);

    // Drain: occupancy stayed at 4 and order is preserved
    popAndCheck("drain1", 2'd1, F1);
    popAndCheck("drain2", 2'd2, F2);
    popAndCheck("drain3", 2'd3, F3);
    popAndCheck("drain4", 2'd1, F4);
    checkOutput("drain_empty", 64'(cmdValid), 64'd0);
    checkOutput("drain_ovf_sticky", 64'(overflow), 64'd1);

    // Update-IR flush with three queued
    applyStimulus(2'd0, D_A);
    applyStimulus(2'd1, D_B);
    applyStimulus(2'd2, D_A);
    checkOutput("flush_pre", 64'(cmdValid), 64'd1);
    vsUir = 1'b1;
    tick();
    tick();
    vsUir = 1'b0;
    repeat (3) tick();
    checkOutput("flush_irupd", 64'(irUpd), 64'd1);
    tick();
    checkOutput("flush_irupd_end", 64'(irUpd), 64'd0);
    checkOutput("flush_valid", 64'(cmdValid), 64'd0);
    checkOutput("flush_act", 64'(takeAction), 64'd0);
    checkOutput("flush_noact", 64'(takeNoAction), 64'd0);
    checkOutput("flush_jdo", 64'(jdo), 64'(F4));
    tick();

    // Reset mid-operation with two queued and overflow set
    applyStimulus(2'd3, F2);
    applyStimulus(2'd0, F3);
    checkOutput("mid_pre_valid", 64'(cmdValid), 64'd1);
    checkOutput("mid_pre_ovf", 64'(overflow), 64'd1);
    checkCounts("mid_pre", 12, 1);
    resetN = 1'b0;
    tick();
    checkOutput("mid_valid", 64'(cmdValid), 64'd0);
    checkOutput("mid_ovf", 64'(overflow), 64'd0);
    checkOutput("mid_jdo", 64'(jdo), 64'd0);
    checkCounts("mid", 0, 0);
    resetN = 1'b1;
    tick();

    // Operation resumes after reset
    applyStimulus(2'd2, D_A);
    popAndCheck("resume", 2'd2, D_A);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
